// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single data-RAM port among NREQ memory requesters
//   (index 0..7 = I, S, A, F, CI, CSS, CL, CS). Requests are served one at a
//   time in round-robin order. Each transaction is latched, driven to the
//   RAM for exactly one cycle and completed with a one-cycle acknowledge.
//   Read data accompanies the acknowledge and is held until the next read.
//
// Ports
//   iCLK        core clock, all state on the rising edge
//   iRST        asynchronous, active-low reset
//   iREQ_CE     per-requester chip enable (bit i = requester i)
//   iREQ_RD     per-requester read strobe
//   iREQ_WR     per-requester write strobe
//   iREQ_ADDR   flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   iREQ_DATA   flattened write data, requester i at [i*DATA_W +: DATA_W]
//   oREQ_ACK    one-hot completion pulse
//   oREQ_DATA   read data broadcast to the acknowledged requester
//   oRAM_CE/RD/WR, oRAM_ADDR, oRAM_DATA   RAM strobes, address, write data
//   iRAM_DATA   RAM read data, valid RAM_LAT cycles after the strobe
//   oGNT_ID     index of the requester owning the current transaction
//   oBUSY       high whenever the arbiter is not idle
//   oERR        one-cycle pulse when a malformed request is seen while idle

module ram_port_arbiter #(
  parameter int NREQ    = 8,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [NREQ-1:0]        iREQ_CE,
  input  logic [NREQ-1:0]        iREQ_RD,
  input  logic [NREQ-1:0]        iREQ_WR,
  input  logic [NREQ*ADDR_W-1:0] iREQ_ADDR,
  input  logic [NREQ*DATA_W-1:0] iREQ_DATA,
  output logic [NREQ-1:0]        oREQ_ACK,
  output logic [DATA_W-1:0]      oREQ_DATA,
  output logic                   oRAM_CE,
  output logic                   oRAM_RD,
  output logic                   oRAM_WR,
  output logic [ADDR_W-1:0]      oRAM_ADDR,
  output logic [DATA_W-1:0]      oRAM_DATA,
  input  logic [DATA_W-1:0]      iRAM_DATA,
  output logic [2:0]             oGNT_ID,
  output logic                   oBUSY,
  output logic                   oERR
);

  // Requester index width is fixed by the 3-bit grant port (up to 8 requesters).
  localparam int ID_W  = 3;
  // Wait counter only needs to hold RAM_LAT-1.
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic             op_write;

  logic [NREQ-1:0]  valid;
  logic [NREQ-1:0]  malformed;
  logic             found;
  logic [ID_W-1:0]  sel;
  logic [NREQ-1:0]  ack_onehot;
  logic [ID_W-1:0]  ptr_next;

  // A request is well formed only when exactly one of RD/WR accompanies CE.
  assign valid     = iREQ_CE &  (iREQ_RD ^ iREQ_WR);
  assign malformed = iREQ_CE & ~(iREQ_RD ^ iREQ_WR);

  // The owner of the transaction is always oGNT_ID, so the ack and the
  // round-robin successor are derived from it.
  assign ack_onehot = {{(NREQ-1){1'b0}}, 1'b1} << oGNT_ID;
  assign ptr_next   = (oGNT_ID == ID_W'(NREQ - 1)) ? '0 : oGNT_ID + 1'b1;

  // Round-robin pick: first valid index scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    int              idx_i;
    logic [ID_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    found = 1'b0;
    sel   = '0;
    idx_i = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(ptr) + k;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      idx = idx_i[ID_W-1:0];
      if (!found && valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Single-process FSM; every output is a register so nothing glitches
  // toward the RAM or the requesters.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from values sampled before the edge.
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      op_write  <= 1'b0;
      oREQ_ACK  <= '0;
      oREQ_DATA <= '0;
      oRAM_CE   <= 1'b0;
      oRAM_RD   <= 1'b0;
      oRAM_WR   <= 1'b0;
      oRAM_ADDR <= '0;
      oRAM_DATA <= '0;
      oGNT_ID   <= '0;
      oBUSY     <= 1'b0;
      oERR      <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state below raises them.
      oREQ_ACK <= '0;
      oERR     <= 1'b0;

      case (state)
        S_IDLE: begin
          oERR <= |malformed;
          if (found) begin
            oGNT_ID   <= sel;
            op_write  <= iREQ_WR[sel];
            oRAM_CE   <= 1'b1;
            oRAM_RD   <= iREQ_RD[sel];
            oRAM_WR   <= iREQ_WR[sel];
            oRAM_ADDR <= iREQ_ADDR[sel*ADDR_W +: ADDR_W];
            oRAM_DATA <= iREQ_DATA[sel*DATA_W +: DATA_W];
            oBUSY     <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // The RAM sees the strobe for this one cycle only.
          oRAM_CE   <= 1'b0;
          oRAM_RD   <= 1'b0;
          oRAM_WR   <= 1'b0;
          oRAM_ADDR <= '0;
          oRAM_DATA <= '0;
          if (op_write) begin
            oREQ_ACK <= ack_onehot;
            state    <= S_DONE;
          end else begin
            cnt   <= CNT_W'(RAM_LAT - 1);
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt == '0) begin
            // Last WAIT cycle is exactly RAM_LAT cycles after the strobe.
            oREQ_DATA <= iRAM_DATA;
            oREQ_ACK  <= ack_onehot;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          ptr   <= ptr_next;
          oBUSY <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: two instances (RAM_LAT=1 and RAM_LAT=3),
// each with its own small RAM model that presents read data only in the
// cycle the arbiter is meant to capture it.

module tb_ram_port_arbiter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance with RAM_LAT = 1 ----------------
  logic         rst1_n;
  logic [7:0]   ce1, rd1, wr1;
  logic [63:0]  addr1;
  logic [255:0] wdata1;
  logic [7:0]   ack1;
  logic [31:0]  rdata1;
  logic         ram_ce1, ram_rd1, ram_wr1;
  logic [7:0]   ram_addr1;
  logic [31:0]  ram_wdata1, ram_rdata1;
  logic [2:0]   gnt1;
  logic         busy1, err1;

  ram_port_arbiter #(.NREQ(8), .ADDR_W(8), .DATA_W(32), .RAM_LAT(1)) u_dut1 (
    .iCLK(clk), .iRST(rst1_n),
    .iREQ_CE(ce1), .iREQ_RD(rd1), .iREQ_WR(wr1),
    .iREQ_ADDR(addr1), .iREQ_DATA(wdata1),
    .oREQ_ACK(ack1), .oREQ_DATA(rdata1),
    .oRAM_CE(ram_ce1), .oRAM_RD(ram_rd1), .oRAM_WR(ram_wr1),
    .oRAM_ADDR(ram_addr1), .oRAM_DATA(ram_wdata1), .iRAM_DATA(ram_rdata1),
    .oGNT_ID(gnt1), .oBUSY(busy1), .oERR(err1)
  );

  // ---------------- instance with RAM_LAT = 3 ----------------
  logic         rst3_n;
  logic [7:0]   ce3, rd3, wr3;
  logic [63:0]  addr3;
  logic [255:0] wdata3;
  logic [7:0]   ack3;
  logic [31:0]  rdata3;
  logic         ram_ce3, ram_rd3, ram_wr3;
  logic [7:0]   ram_addr3;
  logic [31:0]  ram_wdata3, ram_rdata3;
  logic [2:0]   gnt3;
  logic         busy3, err3;

  ram_port_arbiter #(.NREQ(8), .ADDR_W(8), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
    .iCLK(clk), .iRST(rst3_n),
    .iREQ_CE(ce3), .iREQ_RD(rd3), .iREQ_WR(wr3),
    .iREQ_ADDR(addr3), .iREQ_DATA(wdata3),
    .oREQ_ACK(ack3), .oREQ_DATA(rdata3),
    .oRAM_CE(ram_ce3), .oRAM_RD(ram_rd3), .oRAM_WR(ram_wr3),
    .oRAM_ADDR(ram_addr3), .oRAM_DATA(ram_wdata3), .iRAM_DATA(ram_rdata3),
    .oGNT_ID(gnt3), .oBUSY(busy3), .oERR(err3)
  );

  // RAM contents: one special word, every other address returns its byte x4.
  function automatic logic [31:0] ram_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'h12345678 : {4{a}};
  endfunction

  // Latency-1 RAM: data valid only in the cycle right after the strobe.
  always @(posedge clk)
    ram_rdata1 <= (ram_ce1 && ram_rd1) ? ram_val(ram_addr1) : 32'h0;

  // Latency-3 RAM: data valid only in the third cycle after the strobe.
  logic       p0v, p1v;
  logic [7:0] p0a, p1a;
  always @(posedge clk) begin
    p0v        <= ram_ce3 && ram_rd3;
    p0a        <= ram_addr3;
    p1v        <= p0v;
    p1a        <= p0a;
    ram_rdata3 <= p1v ? ram_val(p1a) : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input bit on3, input int i, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [31:0] d);
    if (on3) begin
      ce3[i] = 1'b1; rd3[i] = rd; wr3[i] = wr;
      addr3[i*8 +: 8] = a; wdata3[i*32 +: 32] = d;
    end else begin
      ce1[i] = 1'b1; rd1[i] = rd; wr1[i] = wr;
      addr1[i*8 +: 8] = a; wdata1[i*32 +: 32] = d;
    end
  endtask

  task automatic clr_req(input bit on3, input int i);
    if (on3) begin
      ce3[i] = 1'b0; rd3[i] = 1'b0; wr3[i] = 1'b0;
    end else begin
      ce1[i] = 1'b0; rd1[i] = 1'b0; wr1[i] = 1'b0;
    end
  endtask

  // Step until an ack appears (bounded); returns the ack and edges waited.
  // A timeout returns ack=0, which the caller's comparison then flags.
  task automatic wait_ack(input bit on3, output logic [7:0] a, output int n);
    a = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n++;
      a = on3 ? ack3 : ack1;
      if (a != 8'h0) break;
    end
  endtask

  logic [7:0] a;
  logic [7:0] e;
  int         n;

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0;
    ce1 = '0; rd1 = '0; wr1 = '0; addr1 = '0; wdata1 = '0;
    ce3 = '0; rd3 = '0; wr3 = '0; addr3 = '0; wdata3 = '0;

    // All eight requesters hold a valid write while reset is asserted.
    for (int i = 0; i < 8; i++) set_req(0, i, 1'b0, 1'b1, 8'h80 + 8'(i), 32'hA0 + i);
    tick(2);

    // ---- reset state ----
    check("rst_busy1", busy1, 0);
    check("rst_ack1", ack1, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_ram_ce1", ram_ce1, 0);
    check("rst_err1", err1, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy3", busy3, 0);
    rst1_n = 1'b1; rst3_n = 1'b1;

    // ---- contention: grant order 0..7, one write every 3 cycles ----
    for (int k = 0; k < 8; k++) begin
      wait_ack(0, a, n);
      e = 8'h1 << k;
      check("contention_order", a, e);
      check("contention_gap", n, (k == 0) ? 2 : 3);
      clr_req(0, k);
    end
    // ptr is now 0. Requester 3 is raised first and latched before 0 rises,
    // so 3 is served and then 0.
    set_req(0, 3, 1'b0, 1'b1, 8'h33, 32'h3333_3333);
    tick(2);
    check("rerise_gnt3", gnt1, 3);
    set_req(0, 0, 1'b0, 1'b1, 8'h30, 32'h3030_3030);
    wait_ack(0, a, n);
    check("rerise_ack3", a, 8'b0000_1000);
    clr_req(0, 3);
    wait_ack(0, a, n);
    check("rerise_ack0", a, 8'b0000_0001);
    clr_req(0, 0);
    tick(1);

    // ---- single write from requester 1 (S) ----
    set_req(0, 1, 1'b0, 1'b1, 8'h20, 32'hDEADBEEF);
    tick(1);
    check("wr_ram_ce", ram_ce1, 1);
    check("wr_ram_wr", ram_wr1, 1);
    check("wr_ram_rd", ram_rd1, 0);
    check("wr_ram_addr", ram_addr1, 8'h20);
    check("wr_ram_data", ram_wdata1, 32'hDEADBEEF);
    check("wr_gnt", gnt1, 1);
    check("wr_busy", busy1, 1);
    check("wr_no_early_ack", ack1, 0);
    tick(1);
    check("wr_ack", ack1, 8'b0000_0010);
    check("wr_ram_ce_off", ram_ce1, 0);
    check("wr_ram_addr_off", ram_addr1, 0);
    clr_req(0, 1);
    tick(1);
    check("wr_ack_pulse", ack1, 0);
    check("wr_idle_busy", busy1, 0);

    // ---- single read from requester 6 (CL), RAM_LAT=1 ----
    set_req(0, 6, 1'b1, 1'b0, 8'h10, 32'h0);
    tick(1);
    check("rd_ram_ce", ram_ce1, 1);
    check("rd_ram_rd", ram_rd1, 1);
    check("rd_ram_addr", ram_addr1, 8'h10);
    tick(1);
    check("rd_wait_no_ack", ack1, 0);
    check("rd_wait_ram_ce", ram_ce1, 0);
    tick(1);
    check("rd_ack", ack1, 8'b0100_0000);
    check("rd_data", rdata1, 32'h12345678);
    clr_req(0, 6);
    tick(1);
    check("rd_data_hold", rdata1, 32'h12345678);

    // ---- malformed request 2 alongside valid write 4 ----
    check("mal_err_before", err1, 0);
    set_req(0, 2, 1'b1, 1'b1, 8'h22, 32'h2222_2222);
    set_req(0, 4, 1'b0, 1'b1, 8'h44, 32'h5555_5555);
    tick(1);
    check("mal_gnt", gnt1, 4);
    check("mal_err_idle", err1, 1);
    tick(1);
    check("mal_ack4", ack1, 8'b0001_0000);
    check("mal_err_busy", err1, 0);
    check("mal_wr_keeps_rdata", rdata1, 32'h12345678);
    clr_req(0, 4);
    tick(1);
    check("mal_err_after_done", err1, 0);
    tick(1);
    check("mal_err_pulse_a", err1, 1);
    tick(1);
    check("mal_err_pulse_b", err1, 1);
    check("mal_never_acked", ack1, 0);
    check("mal_never_busy", busy1, 0);
    clr_req(0, 2);
    tick(1);
    check("mal_err_clear", err1, 0);

    // ---- withdrawn read: requester 0 drops CE during ISSUE ----
    set_req(0, 0, 1'b1, 1'b0, 8'h44, 32'h0);
    tick(1);
    check("wd_gnt", gnt1, 0);
    check("wd_ram_rd", ram_rd1, 1);
    clr_req(0, 0);
    tick(1);
    check("wd_wait_no_ack", ack1, 0);
    tick(1);
    check("wd_ack", ack1, 8'b0000_0001);
    check("wd_data", rdata1, 32'h44444444);
    tick(1);

    // ---- RAM_LAT=3 read from requester 2 ----
    set_req(1, 2, 1'b1, 1'b0, 8'h10, 32'h0);
    tick(1);
    check("l3_ram_rd", ram_rd3, 1);
    tick(3);
    check("l3_no_early_ack", ack3, 0);
    check("l3_busy_wait", busy3, 1);
    tick(1);
    check("l3_ack", ack3, 8'b0000_0100);
    check("l3_data", rdata3, 32'h12345678);
    clr_req(1, 2);
    tick(1);

    // ---- reset during WAIT, RAM_LAT=3 ----
    // ptr is 3, so of requesters 1 and 6, 6 is granted first.
    set_req(1, 6, 1'b1, 1'b0, 8'h10, 32'h0);
    set_req(1, 1, 1'b1, 1'b0, 8'h30, 32'h0);
    tick(1);
    check("mr_gnt6", gnt3, 6);
    tick(1);
    check("mr_in_wait", busy3, 1);
    rst3_n = 1'b0;
    #1;
    check("mr_busy0", busy3, 0);
    check("mr_gnt0", gnt3, 0);
    check("mr_ack0", ack3, 0);
    check("mr_rdata0", rdata3, 0);
    check("mr_ram_ce0", ram_ce3, 0);
    tick(2);
    check("mr_hold_no_ack", ack3, 0);
    check("mr_hold_busy", busy3, 0);
    rst3_n = 1'b1;
    tick(1);
    check("mr_fresh_gnt1", gnt3, 1);
    wait_ack(1, a, n);
    check("mr_ack1", a, 8'b0000_0010);
    check("mr_data1", rdata3, 32'h30303030);
    clr_req(1, 1);
    wait_ack(1, a, n);
    check("mr_ack6", a, 8'b0100_0000);
    check("mr_data6", rdata3, 32'h12345678);
    clr_req(1, 6);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the core's single data-RAM port between the per-format memory requesters: I-load, S-store, A-atomic, F-float, CI, CSS, CL and CS. It replaces direct output muxing of the per-format RAM_CE/RD/WR/ADDR/DATA buses. Requesters are served one at a time under round-robin priority. Each transaction is latched, driven to RAM for one cycle and acknowledged with a single-cycle pulse. For reads, the returned data accompanies the acknowledge.

## Interface
- NREQ, 8, number of requesters; index 0..7 = I, S, A, F, CI, CSS, CL, CS
- ADDR_W, 8, RAM address width (matches 8-bit PC/RAM space)
- DATA_W, 32, RAM data width
- RAM_LAT, 1, cycles from RAM strobe to valid iRAM_DATA (1..4)

- iCLK  in  1  core clock, all state on rising edge
- iRST  in  1  reset; asynchronous assert, active-low; synchronous release by design
- iREQ_CE  in  NREQ  per-requester chip enable; bit i = requester i
- iREQ_RD  in  NREQ  per-requester read strobe
- iREQ_WR  in  NREQ  per-requester write strobe
- iREQ_ADDR  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- iREQ_DATA  in  NREQ*DATA_W  flattened write data, same packing
- oREQ_ACK  out  NREQ  one-hot completion pulse
- oREQ_DATA  out  DATA_W  read data returned to the acked requester (broadcast)
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes
- oRAM_ADDR  out  ADDR_W  RAM address
- oRAM_DATA  out  DATA_W  RAM write data
- iRAM_DATA  in  DATA_W  RAM read data
- oGNT_ID  out  3  index of requester owning the current transaction
- oBUSY  out  1  high in every state except IDLE
- oERR  out  1  one-cycle pulse on a malformed request

## Operation
- Valid request i: iREQ_CE[i]=1 and iREQ_RD[i] != iREQ_WR[i].
- Malformed request i: CE=1 with RD==WR. It is never granted. oERR is registered and pulses for each IDLE cycle in which any malformed request is present.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any valid request exists, select the first valid index scanning ptr, ptr+1, …, wrapping mod NREQ.
  - Latch id, op, addr and wdata.
  - Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive oRAM_CE=1 with oRAM_RD/oRAM_WR per the latched op, plus the latched addr/data, for exactly one cycle.
  - Write: go to DONE.
  - Read: load the wait counter with RAM_LAT-1 and go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture iRAM_DATA into oREQ_DATA and go to DONE.
- DONE: oREQ_ACK[id]=1 for one cycle, ptr ← (id+1) mod NREQ, go to IDLE.
- Requesters hold CE/RD/WR/ADDR/DATA stable until they see their ack. They deassert CE on the edge after the ack.
- A request withdrawn after being latched does not abort the transaction; it completes and acks normally.
- oREQ_DATA holds its value until the next read capture. Write transactions leave it unchanged.
- oRAM_* outputs are 0 in every state except ISSUE.
- oGNT_ID holds its value from the latch edge until the next latch.

## Timing
- Reset (iRST=0, any state, any time): FSM→IDLE, ptr=0, counter=0. All outputs go to 0: oREQ_ACK, oREQ_DATA, oRAM_*, oGNT_ID, oBUSY, oERR.
  - An in-flight transaction is dropped with no ack.
- Write, request first seen in IDLE at cycle t: ISSUE at t+1, DONE/ack at t+2. Next grant sampled at t+3.
- Read, same start: ISSUE at t+1, WAIT spanning t+2..t+1+RAM_LAT, with data captured on the last WAIT edge. DONE/ack at t+2+RAM_LAT, with oREQ_DATA valid in the ack cycle.
- Throughput: one write per 3 cycles; one read per 3+RAM_LAT cycles.
- Simultaneous requests: exactly one is granted per IDLE decision. The others wait; no requester starves beyond NREQ-1 grants.
- A requester raising CE during another's transaction is considered at the next IDLE.
- ptr wraps 7→0.

## Test plan
- Single write: req 1 (S), addr 8'h20, data 32'hDEADBEEF → oRAM_WR=1 with that addr/data one cycle after the request; oREQ_ACK=8'b0000_0010 one cycle later.
- Single read, RAM_LAT=1: req 6 (CL), addr 8'h10, RAM returns 32'h12345678 → ack 8'b0100_0000 three cycles after the request, with oREQ_DATA=32'h12345678.
- Contention: all 8 requesters valid from reset, each deasserting after its ack → grant order 0,1,…,7. The test then re-raises 3 and 0: order 3 then 0 (ptr=0 after 7).
- Malformed request: req 2 with CE=1, RD=1, WR=1 alongside a valid req 4 → req 4 is served, req 2 is never acked, oERR pulses each IDLE cycle.
- Reset mid-read, RAM_LAT=3: assert iRST low in WAIT → all outputs 0 immediately and no ack. After release, the still-pending request is granted fresh with ptr=0.
- Withdrawn request: req 0 drops CE in the ISSUE cycle → the transaction still completes and oREQ_ACK[0] pulses.
